// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus: instruction RAM port plus decode-side IR and redirect.
// master = fetch stage, slave = RAM/decode side.
interface ifetch_stage_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] IMEM_ADDR;
   logic [15:0]       IMEM_Q;
   logic              STALL;
   logic              BR_TAKEN;
   logic [ADDR_W-1:0] BR_TARGET;
   logic [15:0]       IR;
   logic [ADDR_W-1:0] IR_PC;
   logic              IR_VALID;
   logic              HALTED;

   modport master (
      output IMEM_ADDR,
      input  IMEM_Q,
      input  STALL,
      input  BR_TAKEN,
      input  BR_TARGET,
      output IR,
      output IR_PC,
      output IR_VALID,
      output HALTED
   );

   modport slave (
      input  IMEM_ADDR,
      output IMEM_Q,
      output STALL,
      output BR_TAKEN,
      output BR_TARGET,
      input  IR,
      input  IR_PC,
      input  IR_VALID,
      input  HALTED
   );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC, IR capture, stall, branch squash.
// Optional IFETCH_HALT_ON_ZERO_EN stops fetch on a zero instruction word.
module ifetch_stage #(
   parameter int ADDR_W   = 10,
   parameter int RESET_PC = 0
) (
   input logic           CLK,
   input logic           RESET,
   ifetch_stage_if.master bus
);
   typedef enum logic {RUN, HALT} state_t;

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(2);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic [ADDR_W-1:0] br_pc;

   assign br_pc = {bus.BR_TARGET[ADDR_W-1:1], 1'b0};

`ifdef IFETCH_HALT_ON_ZERO_EN
   logic halted;
   logic zero_word;

   assign zero_word = (bus.IMEM_Q == 16'h0000);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= RUN;
         pc       <= PC_RST;
         ir       <= 16'h0000;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
      end else if (bus.BR_TAKEN) begin
         state    <= RUN;
         pc       <= br_pc;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
      end else if (!bus.STALL) begin
         unique case (state)
            RUN: begin
               // PC parks on the zero word so a redirect is the only way on
               if (zero_word) begin
                  state    <= HALT;
                  ir_valid <= 1'b0;
                  halted   <= 1'b1;
               end else begin
                  ir       <= bus.IMEM_Q;
                  ir_pc    <= pc;
                  ir_valid <= 1'b1;
                  pc       <= pc + PC_INC;
               end
            end
            HALT: begin
               ir_valid <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state    <= RUN;
               ir_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.HALTED = halted;
`else
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= RUN;
         pc       <= PC_RST;
         ir       <= 16'h0000;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
      end else if (bus.BR_TAKEN) begin
         state    <= RUN;
         pc       <= br_pc;
         ir_valid <= 1'b0;
      end else if (!bus.STALL) begin
         unique case (state)
            RUN: begin
               ir       <= bus.IMEM_Q;
               ir_pc    <= pc;
               ir_valid <= 1'b1;
               pc       <= pc + PC_INC;
            end
            default: begin
               state    <= RUN;
               ir_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.HALTED = 1'b0;
`endif

   assign bus.IMEM_ADDR = pc;
   assign bus.IR        = ir;
   assign bus.IR_PC     = ir_pc;
   assign bus.IR_VALID  = ir_valid;
endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a behavioural instruction RAM.
// Build with IFETCH_HALT_ON_ZERO_EN to cover the halt feature.
module tb_ifetch_stage;
   logic CLK = 1'b0;
   logic RESET;
   int   total = 0;
   int   bad   = 0;
   logic [15:0] mem [512];

   ifetch_stage_if #(.ADDR_W(10)) bus ();

   ifetch_stage #(.ADDR_W(10), .RESET_PC(0)) u_dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.IMEM_Q = mem[bus.IMEM_ADDR[9:1]];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic branch(input logic [9:0] t);
      bus.BR_TAKEN  = 1'b1;
      bus.BR_TARGET = t;
      tick();
      bus.BR_TAKEN  = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick();
      tick();
      total++; if (bus.IMEM_ADDR !== 10'h000) begin bad++; $display("FAIL rst_addr got=%h exp=000", bus.IMEM_ADDR); end
      total++; if (bus.IR !== 16'h0000) begin bad++; $display("FAIL rst_ir got=%h exp=0000", bus.IR); end
      total++; if (bus.IR_PC !== 10'h000) begin bad++; $display("FAIL rst_irpc got=%h exp=000", bus.IR_PC); end
      total++; if (bus.IR_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.IR_VALID); end
      total++; if (bus.HALTED !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", bus.HALTED); end
   endtask

   task automatic test_fetch();
      RESET = 1'b0;
      tick();
      total++; if (bus.IR !== 16'hF001) begin bad++; $display("FAIL f1_ir got=%h exp=f001", bus.IR); end
      total++; if (bus.IR_PC !== 10'h000) begin bad++; $display("FAIL f1_irpc got=%h exp=000", bus.IR_PC); end
      total++; if (bus.IR_VALID !== 1'b1) begin bad++; $display("FAIL f1_valid got=%b exp=1", bus.IR_VALID); end
      tick();
      total++; if (bus.IR !== 16'hF491) begin bad++; $display("FAIL f2_ir got=%h exp=f491", bus.IR); end
      total++; if (bus.IR_PC !== 10'h002) begin bad++; $display("FAIL f2_irpc got=%h exp=002", bus.IR_PC); end
      total++; if (bus.IMEM_ADDR !== 10'h004) begin bad++; $display("FAIL f2_addr got=%h exp=004", bus.IMEM_ADDR); end
   endtask

   task automatic test_stall();
      tick();
      tick();
      total++; if (bus.IMEM_ADDR !== 10'h008) begin bad++; $display("FAIL st_pre_addr got=%h exp=008", bus.IMEM_ADDR); end
      bus.STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus.IR !== 16'h1003) begin bad++; $display("FAIL st_ir[%0d] got=%h exp=1003", i, bus.IR); end
         total++; if (bus.IR_PC !== 10'h006) begin bad++; $display("FAIL st_irpc[%0d] got=%h exp=006", i, bus.IR_PC); end
         total++; if (bus.IR_VALID !== 1'b1) begin bad++; $display("FAIL st_valid[%0d] got=%b exp=1", i, bus.IR_VALID); end
         total++; if (bus.IMEM_ADDR !== 10'h008) begin bad++; $display("FAIL st_addr[%0d] got=%h exp=008", i, bus.IMEM_ADDR); end
      end
      bus.STALL = 1'b0;
      tick();
      total++; if (bus.IR !== 16'h1004) begin bad++; $display("FAIL st_res_ir got=%h exp=1004", bus.IR); end
      total++; if (bus.IR_PC !== 10'h008) begin bad++; $display("FAIL st_res_irpc got=%h exp=008", bus.IR_PC); end
   endtask

   task automatic test_branch_stall();
      bus.STALL = 1'b1;
      branch(10'h01F);
      total++; if (bus.IMEM_ADDR !== 10'h01E) begin bad++; $display("FAIL bs_addr got=%h exp=01e", bus.IMEM_ADDR); end
      total++; if (bus.IR_VALID !== 1'b0) begin bad++; $display("FAIL bs_valid got=%b exp=0", bus.IR_VALID); end
      bus.STALL = 1'b0;
      tick();
      total++; if (bus.IR !== 16'h100F) begin bad++; $display("FAIL bs_ir got=%h exp=100f", bus.IR); end
      total++; if (bus.IR_PC !== 10'h01E) begin bad++; $display("FAIL bs_irpc got=%h exp=01e", bus.IR_PC); end
      total++; if (bus.IR_VALID !== 1'b1) begin bad++; $display("FAIL bs_valid2 got=%b exp=1", bus.IR_VALID); end
   endtask

   task automatic test_wrap();
      branch(10'h3FC);
      tick();
      total++; if (bus.IR_PC !== 10'h3FC) begin bad++; $display("FAIL wr_irpc0 got=%h exp=3fc", bus.IR_PC); end
      total++; if (bus.IR !== 16'h11FE) begin bad++; $display("FAIL wr_ir0 got=%h exp=11fe", bus.IR); end
      tick();
      total++; if (bus.IR_PC !== 10'h3FE) begin bad++; $display("FAIL wr_irpc1 got=%h exp=3fe", bus.IR_PC); end
      total++; if (bus.IMEM_ADDR !== 10'h000) begin bad++; $display("FAIL wr_addr got=%h exp=000", bus.IMEM_ADDR); end
      tick();
      total++; if (bus.IR_PC !== 10'h000) begin bad++; $display("FAIL wr_irpc2 got=%h exp=000", bus.IR_PC); end
      total++; if (bus.IR !== 16'hF001) begin bad++; $display("FAIL wr_ir2 got=%h exp=f001", bus.IR); end
   endtask

   task automatic test_back_to_back();
      bus.BR_TAKEN  = 1'b1;
      bus.BR_TARGET = 10'h100;
      tick();
      bus.BR_TARGET = 10'h201;
      tick();
      bus.BR_TAKEN  = 1'b0;
      total++; if (bus.IMEM_ADDR !== 10'h200) begin bad++; $display("FAIL bb_addr got=%h exp=200", bus.IMEM_ADDR); end
      total++; if (bus.IR_VALID !== 1'b0) begin bad++; $display("FAIL bb_valid got=%b exp=0", bus.IR_VALID); end
      tick();
      total++; if (bus.IR_PC !== 10'h200) begin bad++; $display("FAIL bb_irpc got=%h exp=200", bus.IR_PC); end
      total++; if (bus.IR !== 16'h1100) begin bad++; $display("FAIL bb_ir got=%h exp=1100", bus.IR); end
   endtask

   task automatic test_zero_word();
      branch(10'h030);
      for (int i = 0; i < 4; i++) tick();
      total++; if (bus.IR_PC !== 10'h036) begin bad++; $display("FAIL zw_irpc got=%h exp=036", bus.IR_PC); end
      total++; if (bus.IR !== 16'h101B) begin bad++; $display("FAIL zw_ir got=%h exp=101b", bus.IR); end
      tick();
`ifdef IFETCH_HALT_ON_ZERO_EN
      for (int i = 0; i < 10; i++) begin
         total++; if (bus.HALTED !== 1'b1) begin bad++; $display("FAIL hz_halted[%0d] got=%b exp=1", i, bus.HALTED); end
         total++; if (bus.IR_VALID !== 1'b0) begin bad++; $display("FAIL hz_valid[%0d] got=%b exp=0", i, bus.IR_VALID); end
         total++; if (bus.IMEM_ADDR !== 10'h038) begin bad++; $display("FAIL hz_addr[%0d] got=%h exp=038", i, bus.IMEM_ADDR); end
         tick();
      end
      branch(10'h000);
      total++; if (bus.HALTED !== 1'b0) begin bad++; $display("FAIL hz_rel_halted got=%b exp=0", bus.HALTED); end
      total++; if (bus.IMEM_ADDR !== 10'h000) begin bad++; $display("FAIL hz_rel_addr got=%h exp=000", bus.IMEM_ADDR); end
      tick();
      total++; if (bus.IR !== 16'hF001) begin bad++; $display("FAIL hz_rel_ir got=%h exp=f001", bus.IR); end
      total++; if (bus.IR_VALID !== 1'b1) begin bad++; $display("FAIL hz_rel_valid got=%b exp=1", bus.IR_VALID); end
`else
      total++; if (bus.IR !== 16'h0000) begin bad++; $display("FAIL nz_ir got=%h exp=0000", bus.IR); end
      total++; if (bus.IR_VALID !== 1'b1) begin bad++; $display("FAIL nz_valid got=%b exp=1", bus.IR_VALID); end
      total++; if (bus.IR_PC !== 10'h038) begin bad++; $display("FAIL nz_irpc got=%h exp=038", bus.IR_PC); end
      total++; if (bus.IMEM_ADDR !== 10'h03A) begin bad++; $display("FAIL nz_addr got=%h exp=03a", bus.IMEM_ADDR); end
      total++; if (bus.HALTED !== 1'b0) begin bad++; $display("FAIL nz_halted got=%b exp=0", bus.HALTED); end
`endif
   endtask

   task automatic test_reset_mid();
      branch(10'h040);
      tick();
      total++; if (bus.IMEM_ADDR !== 10'h042) begin bad++; $display("FAIL rm_pre_addr got=%h exp=042", bus.IMEM_ADDR); end
      bus.BR_TAKEN  = 1'b1;
      bus.BR_TARGET = 10'h100;
      RESET = 1'b1;
      tick();
      bus.BR_TAKEN = 1'b0;
      total++; if (bus.IMEM_ADDR !== 10'h000) begin bad++; $display("FAIL rm_addr got=%h exp=000", bus.IMEM_ADDR); end
      total++; if (bus.IR_VALID !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", bus.IR_VALID); end
      total++; if (bus.HALTED !== 1'b0) begin bad++; $display("FAIL rm_halted got=%b exp=0", bus.HALTED); end
      total++; if (bus.IR !== 16'h0000) begin bad++; $display("FAIL rm_ir got=%h exp=0000", bus.IR); end
      RESET = 1'b0;
      tick();
      total++; if (bus.IR !== 16'hF001) begin bad++; $display("FAIL rm_ir2 got=%h exp=f001", bus.IR); end
      total++; if (bus.IR_PC !== 10'h000) begin bad++; $display("FAIL rm_irpc2 got=%h exp=000", bus.IR_PC); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0]  = 16'hF001;
      mem[1]  = 16'hF491;
      mem[28] = 16'h0000;
      RESET         = 1'b1;
      bus.STALL     = 1'b0;
      bus.BR_TAKEN  = 1'b0;
      bus.BR_TARGET = 10'h000;
      test_reset();
      test_fetch();
      test_stall();
      test_branch_stall();
      test_wrap();
      test_back_to_back();
      test_zero_word();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage of the 16-bit minesweeper CPU, sitting directly upstream of the instruction RAM.
- Owns the program counter and drives the byte address into the instruction RAM, whose read is combinational with word index ADDR[9:1].
- Captures the returned 16-bit word into an instruction register (IR) for decode.
- Handles stall, branch redirect with squash, and an optional halt-on-zero-word condition.

Parameters:
- ADDR_W, 10, byte-address width of the instruction RAM.
- RESET_PC, 0, byte address loaded into the PC on reset. Must be even.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- IMEM_ADDR  out  ADDR_W  byte address to the instruction RAM; always equals PC
- IMEM_Q  in  16  instruction word from the RAM, combinational from IMEM_ADDR
- STALL  in  1  decode/execute back-pressure; hold the current fetch
- BR_TAKEN  in  1  branch/jump resolved taken this cycle
- BR_TARGET  in  ADDR_W  redirect byte address; bit 0 is ignored (forced 0)
- IR  out  16  registered instruction
- IR_PC  out  ADDR_W  byte address IR was fetched from
- IR_VALID  out  1  IR holds a live instruction
- HALTED  out  1  fetch has stopped (only with the optional feature, else tied 0)

Behaviour:
- Registers: PC, IR, IR_PC, IR_VALID, state (RUN, HALT).
- Reset values: PC=RESET_PC, IR=16'h0000, IR_PC=0, IR_VALID=0, HALTED=0, state=RUN.
- IMEM_ADDR=PC combinationally. Fetch latency is 1 cycle: the word at PC appears on IR on the next CLK edge.
- Priority each edge: RESET > BR_TAKEN > STALL > normal advance.
- RESET: applies the reset values regardless of all other inputs. The RAM reloads its contents during the same RESET cycles, so the first fetch is issued in the first cycle RESET is low. Reset mid-run discards IR and any pending redirect.
- BR_TAKEN (any state): PC<={BR_TARGET[ADDR_W-1:1],1'b0}, IR_VALID<=0 (squashes the wrong-path word), state<=RUN. Overrides STALL in the same cycle. IR and IR_PC may update but are don't-care while IR_VALID=0.
- STALL=1 with no branch: PC, IR, IR_PC, IR_VALID all hold.
- Normal advance in RUN: IR<=IMEM_Q, IR_PC<=PC, IR_VALID<=1, PC<=PC+2.
- PC arithmetic is modulo 2^ADDR_W. Wrap: 0x3FE+2 -> 0x000 with no flag.
- PC[0] is always 0. An odd BR_TARGET is silently rounded down.
- HALT state holds PC and IR, with IR_VALID=0 and HALTED=1. Only BR_TAKEN or RESET leave HALT.
- Back-to-back branches: each BR_TAKEN cycle redirects; the last one wins.

Optional Feature:
- Macro IFETCH_HALT_ON_ZERO_EN. The RAM's unused words are zero-filled, so a zero word marks the end of the program.
- Defined, on a normal advance where IMEM_Q==16'h0000:
  - state<=HALT, HALTED<=1, IR_VALID<=0, PC holds at the zero word's address.
  - The zero word is never presented as valid.
  - STALL in the same cycle defers detection until STALL falls.
- Not defined:
  - 16'h0000 is an ordinary instruction: IR_VALID=1, PC keeps advancing and wraps.
  - HALT state is unreachable and HALTED is tied 0.

Test Plan:
- Reset then release, RAM word0=0xF001, word1=0xF491 -> cycle1: IR=0xF001, IR_PC=0, VALID=1; cycle2: IR=0xF491, IR_PC=2; IMEM_ADDR=4.
- STALL high for 3 cycles at PC=8 -> IR/IR_PC/IR_VALID/PC unchanged for 3 edges, then fetch resumes from address 8.
- BR_TAKEN with BR_TARGET=0x01F and STALL=1 same cycle -> next edge: PC=0x01E, IR_VALID=0; following edge: IR=word 15, IR_PC=0x01E.
- Free-run from PC=0x3FC -> IR_PC sequence 0x3FC, 0x3FE, 0x000 with no stall.
- IFETCH_HALT_ON_ZERO_EN defined, word28=0 -> after IR_PC=0x036 (word 27), HALTED=1, IR_VALID=0, PC=0x038 held 10+ cycles; then BR_TAKEN to 0 -> HALTED=0 and fetch restarts at 0. Macro undefined, same program -> IR=0x0000 with IR_VALID=1, PC advances to 0x03A.
- RESET asserted mid-stream at PC=0x040 -> next edge: PC=0, IR_VALID=0, HALTED=0.
